// File: rtl/decoder_nxm_scan_pkg.sv
// Shared constants and types for the N-to-2^N registered decoder and its scan prescaler.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Bits needed to count 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_nxm_scan_prescaler.sv
// Free-running 0..PRESCALE-1 counter; tick is the combinational terminal-count strobe while running.
module scan_prescaler
    import decoder_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    // A one-cycle period still needs a 1-bit counter that simply sits at zero.
    localparam int CW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TC = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_nxm_scan.sv
// Registered N-to-2^N one-hot decoder with a DIRECT select mode and an auto-stepping SCAN ring mode.
module decoder_nxm_scan
    import decoder_pkg::*;
#(
    parameter int N          = 2,
    parameter int PRESCALE   = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              mode,
    input  logic [N-1:0]      sel,
    input  logic              load,
    output logic [0:(2**N)-1] D,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int OUTS = 2**N;

    state_t         state, state_n;
    logic [N-1:0]   idx_n;
    logic           wrap_n;
    logic           run, clr, tick;

    function automatic logic [0:OUTS-1] decode(input logic [N-1:0] i, input logic on);
        logic [0:OUTS-1] v;
        for (int k = 0; k < OUTS; k++) begin
            v[k] = on && (i == N'(k));
        end
        return (ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    always_comb begin
        state_n = ST_OFF;
        if (enable) begin
            state_n = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
    end

    // The prescaler only needs clearing once on entry to DIRECT; it then holds because run is low.
    assign run = (state_n == ST_SCAN);
    assign clr = ((state_n == ST_SCAN) && load) ||
                 ((state_n == ST_DIRECT) && (state != ST_DIRECT));

    scan_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .run (run),
        .tick(tick)
    );

    always_comb begin
        idx_n  = idx;
        wrap_n = 1'b0;
        case (state_n)
            ST_DIRECT: idx_n = sel;
            ST_SCAN: begin
                if (load) begin
                    idx_n = sel;
                end else if (tick) begin
                    idx_n  = idx + 1'b1;
                    wrap_n = (idx == N'(OUTS - 1));
                end
            end
            default: idx_n = idx;
        endcase
    end

    // D decodes the index being written this edge, so D and idx always move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OFF;
            idx   <= '0;
            wrap  <= 1'b0;
            D     <= decode('0, 1'b0);
        end else begin
            state <= state_n;
            idx   <= idx_n;
            wrap  <= wrap_n;
            D     <= decode(idx_n, state_n != ST_OFF);
        end
    end

endmodule

// File: tb/tb_decoder_nxm_scan.sv
// Directed bench for decoder_nxm_scan: a reference model pushes expectations, checked after each edge.
module tb_decoder_nxm_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, md_a, ld_a;
    logic [1:0] sl_a;
    logic [0:3] d_a;
    logic [1:0] idx_a;
    logic       wrap_a;

    logic       rst_b, en_b, md_b, ld_b;
    logic [2:0] sl_b;
    logic [0:7] d_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    decoder_nxm_scan #(.N(2), .PRESCALE(4), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .mode(md_a), .sel(sl_a), .load(ld_a),
        .D(d_a), .idx(idx_a), .wrap(wrap_a)
    );

    decoder_nxm_scan #(.N(3), .PRESCALE(1), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .mode(md_b), .sel(sl_b), .load(ld_b),
        .D(d_b), .idx(idx_b), .wrap(wrap_b)
    );

    typedef struct {
        logic [7:0] d;
        int         idx;
        logic       wrap;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";
    int    ma_idx = 0, ma_pre = 0, mb_idx = 0, mb_pre = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model(input int n, input int ps, input int al, input logic rs,
                         input logic en, input logic md, input logic ld, input int sl,
                         inout int idx, inout int pre, output exp_t e);
        int         outs;
        int         wr;
        logic [7:0] inact, oh;
        outs  = 1 << n;
        inact = (al != 0) ? 8'((1 << outs) - 1) : 8'h00;
        wr    = 0;
        if (rs) begin
            idx = 0;
            pre = 0;
        end else if (!en) begin
            wr = 0;
        end else if (!md) begin
            idx = sl;
            pre = 0;
        end else if (ld) begin
            idx = sl;
            pre = 0;
        end else if (pre == ps - 1) begin
            pre = 0;
            if (idx == outs - 1) wr = 1;
            idx = (idx + 1) % outs;
        end else begin
            pre++;
        end
        oh     = 8'(1 << (outs - 1 - idx));
        e.d    = (rs || !en) ? inact : ((al != 0) ? (inact ^ oh) : oh);
        e.idx  = idx;
        e.wrap = (wr != 0);
    endtask

    task automatic step();
        exp_t ea, eb;
        model(2, 4, 0, rst_a, en_a, md_a, ld_a, int'(sl_a), ma_idx, ma_pre, ea);
        q.push_back(ea);
        model(3, 1, 1, rst_b, en_b, md_b, ld_b, int'(sl_b), mb_idx, mb_pre, eb);
        q.push_back(eb);
        @(posedge clk);
        #1;
        ea = q.pop_front();
        chk("a_d", 8'(d_a), ea.d);
        chk("a_idx", 8'(idx_a), 8'(ea.idx));
        chk("a_wrap", {7'b0, wrap_a}, {7'b0, ea.wrap});
        eb = q.pop_front();
        chk("b_d", 8'(d_b), eb.d);
        chk("b_idx", 8'(idx_b), 8'(eb.idx));
        chk("b_wrap", {7'b0, wrap_b}, {7'b0, eb.wrap});
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; md_a = 1'b0; ld_a = 1'b0; sl_a = 2'd0;
        rst_b = 1'b1; en_b = 1'b0; md_b = 1'b0; ld_b = 1'b0; sl_b = 3'd0;

        phase = "reset";
        step();
        step();
        chk("d_a_rst", 8'(d_a), 8'h00);
        chk("idx_a_rst", 8'(idx_a), 8'h00);
        chk("d_b_rst", 8'(d_b), 8'hFF);

        phase = "off";
        rst_a = 1'b0; rst_b = 1'b0;
        en_b = 1'b1; md_b = 1'b1; ld_b = 1'b1; sl_b = 3'd0;
        step();
        chk("d_a_off", 8'(d_a), 8'h00);
        chk("d_b_ring0", 8'(d_b), 8'b0111_1111);
        ld_b = 1'b0;
        step();
        chk("d_b_ring1", 8'(d_b), 8'b1011_1111);

        phase = "enable";
        en_a = 1'b1; md_a = 1'b0; sl_a = 2'd2;
        step();
        chk("d_a_sel2", 8'(d_a), 8'b0000_0010);

        phase = "sweep";
        for (int i = 0; i < 4; i++) begin
            sl_a = 2'(i);
            step();
            chk("d_a_sweep", 8'(d_a), 8'(4'b1000 >> i));
        end
        en_a = 1'b0;
        step();
        chk("d_a_dis", 8'(d_a), 8'h00);

        phase = "scan";
        en_a = 1'b1; md_a = 1'b1; ld_a = 1'b1; sl_a = 2'd3;
        step();
        chk("idx_load3", 8'(idx_a), 8'd3);
        ld_a = 1'b0; sl_a = 2'd0;
        repeat (3) step();
        step();
        chk("idx_wrapped", 8'(idx_a), 8'd0);
        chk("wrap_pulse", {7'b0, wrap_a}, 8'd1);
        step();
        chk("wrap_drop", {7'b0, wrap_a}, 8'd0);
        repeat (3) step();
        chk("idx_step1", 8'(idx_a), 8'd1);

        phase = "collide";
        ld_a = 1'b1; sl_a = 2'd3;
        step();
        ld_a = 1'b0;
        repeat (3) step();
        ld_a = 1'b1; sl_a = 2'd1;
        step();
        chk("idx_coll", 8'(idx_a), 8'd1);
        chk("wrap_coll", {7'b0, wrap_a}, 8'd0);
        ld_a = 1'b0;
        repeat (3) step();
        chk("idx_hold", 8'(idx_a), 8'd1);
        step();
        chk("idx_after", 8'(idx_a), 8'd2);

        phase = "freeze";
        ld_a = 1'b1; sl_a = 2'd2;
        step();
        ld_a = 1'b0;
        repeat (2) step();
        en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("d_frozen", 8'(d_a), 8'h00);
            chk("idx_frozen", 8'(idx_a), 8'd2);
        end
        en_a = 1'b1;
        step();
        chk("idx_resume1", 8'(idx_a), 8'd2);
        step();
        chk("idx_resume2", 8'(idx_a), 8'd3);

        phase = "switch";
        md_a = 1'b0; sl_a = 2'd1; ld_a = 1'b1;
        step();
        chk("idx_direct", 8'(idx_a), 8'd1);
        md_a = 1'b1; ld_a = 1'b0; sl_a = 2'd3;
        repeat (4) step();
        chk("idx_from_direct", 8'(idx_a), 8'd2);
        en_a = 1'b0; ld_a = 1'b1; sl_a = 2'd0;
        step();
        chk("idx_off_load", 8'(idx_a), 8'd2);
        ld_a = 1'b0; en_a = 1'b1;

        phase = "b_reset";
        repeat (3) step();
        rst_b = 1'b1;
        step();
        chk("d_b_midrst", 8'(d_b), 8'hFF);
        chk("idx_b_midrst", 8'(idx_b), 8'd0);
        chk("wrap_b_midrst", {7'b0, wrap_b}, 8'd0);
        rst_b = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
